// File: rtl/axi_eth_pkg.sv
// Shared constants, state/destination enums and the output beat payload for the
// Ethernet RX dispatcher (single-tag VLAN support selected by AXI_ETH_RX_VLAN_EN).
package axi_eth_pkg;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
    localparam int unsigned ETH_HDR_LEN    = 14;
    localparam int unsigned VLAN_TAG_LEN   = 4;
    localparam int unsigned HDR_IDX_W      = 5;

    typedef enum logic [1:0] {HDR, FWD, DROP} state_e;
    typedef enum logic {DEST_ARP, DEST_IP} dest_e;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        dest_e      dest;
    } axis_beat_t;

    // Byte idx (0 = first on the wire) of a 48-bit MAC address.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            default: return mac[7:0];
        endcase
    endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// One-entry AXI-Stream register; the dest sideband selects which sink drains it.
module axis_pipe_reg
    import axi_eth_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  axis_beat_t beat_i,
    input  logic       arp_ready_i,
    input  logic       ip_ready_i,
    output logic       can_load_c_o,
    output logic       valid_o,
    output axis_beat_t beat_o
);

    logic       valid_q, valid_d;
    axis_beat_t beat_q, beat_d;
    logic       sel_ready_c;

    assign sel_ready_c  = (beat_q.dest == DEST_ARP) ? arp_ready_i : ip_ready_i;
    assign can_load_c_o = ~valid_q | sel_ready_c;
    assign valid_o      = valid_q;
    assign beat_o       = beat_q;

    // A load in the same cycle as a drain keeps the register full.
    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (load_i) begin
            valid_d = 1'b1;
            beat_d  = beat_i;
        end else if (valid_q && sel_ready_c) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: rtl/axi_eth_rx_dispatch.sv
// Ethernet RX front-end: strips the MAC header, filters on destination MAC and steers
// ARP / IPv4 payloads to their streams. Define AXI_ETH_RX_VLAN_EN to accept one 802.1Q tag.
module axi_eth_rx_dispatch
    import axi_eth_pkg::*;
#(
    parameter logic [23:0] MAC_MSB = 24'h010203,
    parameter logic [23:0] MAC_LSB = 24'h040506,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             s_axis_tvalid,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic             m_axis_arp_tvalid,
    output logic [7:0]       m_axis_arp_tdata,
    output logic             m_axis_arp_tlast,
    input  logic             m_axis_arp_tready,
    output logic             m_axis_ip_tvalid,
    output logic [7:0]       m_axis_ip_tdata,
    output logic             m_axis_ip_tlast,
    input  logic             m_axis_ip_tready,
    output logic [CNT_W-1:0] rx_arp_cnt,
    output logic [CNT_W-1:0] rx_ip_cnt,
    output logic [CNT_W-1:0] rx_drop_cnt
);

    localparam logic [47:0] OWN_MAC = {MAC_MSB, MAC_LSB};
    localparam logic [HDR_IDX_W-1:0] IDX_MAC_END    = HDR_IDX_W'(6);
    localparam logic [HDR_IDX_W-1:0] IDX_ET_HI      = HDR_IDX_W'(ETH_HDR_LEN - 2);
    localparam logic [HDR_IDX_W-1:0] IDX_ET_LO      = HDR_IDX_W'(ETH_HDR_LEN - 1);
    localparam logic [HDR_IDX_W-1:0] IDX_VLAN_ET_HI = HDR_IDX_W'(ETH_HDR_LEN + VLAN_TAG_LEN - 2);
    localparam logic [HDR_IDX_W-1:0] IDX_VLAN_ET_LO = HDR_IDX_W'(ETH_HDR_LEN + VLAN_TAG_LEN - 1);

    state_e               state_q, state_d;
    logic [HDR_IDX_W-1:0] idx_q, idx_d;
    logic                 own_q, own_d, bc_q, bc_d, vlan_q, vlan_d;
    logic [7:0]           et_hi_q, et_hi_d;
    dest_e                dest_q, dest_d;
    logic [CNT_W-1:0]     arp_cnt_q, ip_cnt_q, drop_cnt_q;

    logic                 xfer_c, ready_c, load_c, can_load_c, out_valid;
    logic                 mac_hit_c, mac_bc_c, mac_ok_c, is_tag_c;
    logic                 arp_inc_c, ip_inc_c, drop_inc_c;
    logic [15:0]          ethertype_c;
    logic [HDR_IDX_W-1:0] hdr_end_c;
    axis_beat_t           beat_in_c, beat_out;

    assign s_axis_tready = aresetn & ready_c;
    assign xfer_c        = s_axis_tvalid & s_axis_tready;
    assign ethertype_c   = {et_hi_q, s_axis_tdata};
    assign hdr_end_c     = vlan_q ? IDX_VLAN_ET_LO : IDX_ET_LO;
    assign mac_hit_c     = (s_axis_tdata == mac_byte(OWN_MAC, idx_q[2:0]));
    assign mac_bc_c      = (s_axis_tdata == 8'hff);
    assign mac_ok_c      = own_q | bc_q;
    assign beat_in_c     = {s_axis_tdata, s_axis_tlast, dest_q};

`ifdef AXI_ETH_RX_VLAN_EN
    assign is_tag_c = ~vlan_q & (ethertype_c == ETHERTYPE_VLAN);
`else
    assign is_tag_c = 1'b0;
`endif

    // Header parse, steering decision and per-frame accounting.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        own_d      = own_q;
        bc_d       = bc_q;
        vlan_d     = vlan_q;
        et_hi_d    = et_hi_q;
        dest_d     = dest_q;
        ready_c    = 1'b1;
        load_c     = 1'b0;
        arp_inc_c  = 1'b0;
        ip_inc_c   = 1'b0;
        drop_inc_c = 1'b0;
        case (state_q)
            HDR: begin
                if (xfer_c) begin
                    idx_d = idx_q + HDR_IDX_W'(1);
                    if (idx_q == '0) begin
                        own_d = mac_hit_c;
                        bc_d  = mac_bc_c;
                    end else if (idx_q < IDX_MAC_END) begin
                        own_d = own_q & mac_hit_c;
                        bc_d  = bc_q & mac_bc_c;
                    end
                    if (idx_q == IDX_ET_HI || idx_q == IDX_VLAN_ET_HI) et_hi_d = s_axis_tdata;
                    if (s_axis_tlast) begin
                        drop_inc_c = 1'b1;
                        idx_d      = '0;
                        vlan_d     = 1'b0;
                    end else if (idx_q == hdr_end_c) begin
                        if (is_tag_c) begin
                            vlan_d = 1'b1;
                        end else begin
                            idx_d  = '0;
                            vlan_d = 1'b0;
                            if (mac_ok_c && ethertype_c == ETHERTYPE_ARP) begin
                                state_d = FWD;
                                dest_d  = DEST_ARP;
                            end else if (mac_ok_c && ethertype_c == ETHERTYPE_IPV4) begin
                                state_d = FWD;
                                dest_d  = DEST_IP;
                            end else begin
                                state_d    = DROP;
                                drop_inc_c = 1'b1;
                            end
                        end
                    end
                end
            end
            FWD: begin
                ready_c = can_load_c;
                if (xfer_c) begin
                    load_c = 1'b1;
                    if (s_axis_tlast) begin
                        state_d   = HDR;
                        idx_d     = '0;
                        arp_inc_c = (dest_q == DEST_ARP);
                        ip_inc_c  = (dest_q == DEST_IP);
                    end
                end
            end
            DROP: begin
                if (xfer_c && s_axis_tlast) begin
                    state_d = HDR;
                    idx_d   = '0;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= HDR;
            idx_q      <= '0;
            own_q      <= 1'b0;
            bc_q       <= 1'b0;
            vlan_q     <= 1'b0;
            et_hi_q    <= '0;
            dest_q     <= DEST_ARP;
            arp_cnt_q  <= '0;
            ip_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            own_q   <= own_d;
            bc_q    <= bc_d;
            vlan_q  <= vlan_d;
            et_hi_q <= et_hi_d;
            dest_q  <= dest_d;
            if (arp_inc_c)  arp_cnt_q  <= arp_cnt_q + CNT_W'(1);
            if (ip_inc_c)   ip_cnt_q   <= ip_cnt_q + CNT_W'(1);
            if (drop_inc_c) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    axis_pipe_reg u_out_reg (
        .clk          (clk),
        .rst_n        (aresetn),
        .load_i       (load_c),
        .beat_i       (beat_in_c),
        .arp_ready_i  (m_axis_arp_tready),
        .ip_ready_i   (m_axis_ip_tready),
        .can_load_c_o (can_load_c),
        .valid_o      (out_valid),
        .beat_o       (beat_out)
    );

    assign m_axis_arp_tvalid = out_valid & (beat_out.dest == DEST_ARP);
    assign m_axis_ip_tvalid  = out_valid & (beat_out.dest == DEST_IP);
    assign m_axis_arp_tdata  = beat_out.data;
    assign m_axis_ip_tdata   = beat_out.data;
    assign m_axis_arp_tlast  = beat_out.last;
    assign m_axis_ip_tlast   = beat_out.last;
    assign rx_arp_cnt        = arp_cnt_q;
    assign rx_ip_cnt         = ip_cnt_q;
    assign rx_drop_cnt       = drop_cnt_q;

endmodule

// File: doc/axi_eth_rx_dispatch.md
Name: axi_eth_rx_dispatch

Overview:
- Ethernet RX front-end ahead of the ARP receiver and the IPv4/UDP receiver.
- Consumes a byte-wide AXI-Stream frame with no FCS and strips the 14-byte MAC header.
- Filters on destination MAC (own or broadcast), then steers the payload by EtherType to the ARP or IPv4 output stream.
- Everything else is dropped and counted; the block sequences which downstream parser sees each frame.

Parameters:
- MAC_MSB, 24'h010203, upper 3 bytes of own MAC address.
- MAC_LSB, 24'h040506, lower 3 bytes of own MAC address.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; asynchronous assert, active-low.
- s_axis_tvalid  in  1  input frame byte valid.
- s_axis_tdata  in  8  input frame byte.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tready  out  1  input accept.
- m_axis_arp_tvalid / m_axis_arp_tdata[8] / m_axis_arp_tlast  out  ARP payload stream.
- m_axis_arp_tready  in  1  ARP sink ready.
- m_axis_ip_tvalid / m_axis_ip_tdata[8] / m_axis_ip_tlast  out  IPv4 payload stream.
- m_axis_ip_tready  in  1  IPv4 sink ready.
- rx_arp_cnt  out  CNT_W  frames forwarded to ARP.
- rx_ip_cnt  out  CNT_W  frames forwarded to IPv4.
- rx_drop_cnt  out  CNT_W  frames dropped.

Behaviour:
- Reset (aresetn=0, asynchronous): state=HDR, byte index=0, output register empty, all counters 0.
  - Both m_*_tvalid=0.
  - s_axis_tready=0 only while aresetn=0.
- Byte handshake: a byte transfers when s_axis_tvalid & s_axis_tready.
- States:
  - HDR (s_axis_tready=1):
    - Bytes 0-5 compared against {MAC_MSB,MAC_LSB} and 48'hffffffffffff; the flags are cleared at index 0.
    - Bytes 6-11 (source MAC) ignored.
    - Bytes 12-13 form the EtherType.
    - Decision on the transfer of byte 13:
      - tlast on any header byte: runt → rx_drop_cnt+1, index=0, stay HDR.
      - MAC mismatch, or EtherType not 16'h0806/16'h0800 → DROP, rx_drop_cnt+1.
      - 16'h0806 → FWD with dest=ARP.
      - 16'h0800 → FWD with dest=IP.
  - FWD:
    - Payload bytes go into a one-entry output register holding {data, last, dest}.
    - s_axis_tready = ~out_valid | ready(out_dest).
    - On transfer of a tlast byte: counter for dest +1 (counted on input acceptance), index=0, → HDR.
  - DROP: s_axis_tready=1, bytes discarded; tlast → HDR, index=0.
- Output register:
  - m_axis_arp_tvalid = out_valid & out_dest==ARP; IP likewise.
  - out_valid clears when the selected sink accepts and no new byte loads in the same cycle.
  - Simultaneous drain and load is allowed, giving full throughput.
  - Latency: byte accepted in cycle N is presented in cycle N+1.
- The register may still hold the previous frame's last byte while the next header is consumed; it drains independently, and HDR never writes it.
- A zero-length payload cannot occur; tlast at byte 13 is a runt.
- Counters wrap modulo 2^CNT_W.
- Backpressure stalls only FWD; header and drop bytes are never stalled.

Optional Feature:
- Macro AXI_ETH_RX_VLAN_EN.
- Defined:
  - EtherType 16'h8100 at bytes 12-13 means bytes 14-15 (TCI) are ignored and bytes 16-17 are the real EtherType.
  - The decision moves to byte 17 and the runt check extends to byte 17.
  - A second 16'h8100 tag is dropped.
- Undefined: 16'h8100 is an unknown EtherType → DROP.

Decomposition:
- Package axi_eth_pkg holds:
  - ETHERTYPE_ARP=16'h0806, ETHERTYPE_IPV4=16'h0800, ETHERTYPE_VLAN=16'h8100, ETH_HDR_LEN=14.
  - State enum {HDR, FWD, DROP}.
  - Dest enum {DEST_ARP, DEST_IP}.
- Sub-module axis_pipe_reg: one-entry AXI-Stream register carrying dest as sideband; instantiated once.

Test Plan:
- Broadcast ARP frame (dst ff:ff:ff:ff:ff:ff, type 0806, 28-byte payload), sinks always ready → 28 bytes on m_axis_arp with tlast on byte 28; rx_arp_cnt=1; m_axis_ip_tvalid never 1.
- Unicast IPv4 to 01:02:03:04:05:06, type 0800, 20-byte payload; m_axis_ip_tready toggles 1/0 each cycle → payload intact and in order; s_axis_tready low only while the register is full and the sink is not ready; rx_ip_cnt=1.
- Frame to 01:02:03:04:05:07, or type 86dd → no output valid; s_axis_tready=1 throughout; rx_drop_cnt increments by 1 per frame.
- 10-byte runt with tlast → rx_drop_cnt=1, next valid ARP frame forwarded correctly.
- Back-to-back IP then ARP frames with m_axis_ip_tready=0 held → IP last byte stays in the register while the ARP header is consumed; ARP bytes stall until m_axis_ip_tready=1; nothing is misrouted.
- aresetn pulsed low mid-payload → outputs invalid and counters 0 immediately; the remainder of the frame is parsed as a header and counted as a runt when its tlast arrives.
- With AXI_ETH_RX_VLAN_EN: tag 8100/0064, then 0806 → forwarded to ARP.
- Without AXI_ETH_RX_VLAN_EN: the same tagged frame is dropped.
